// File: rtl/digit_len_seq.sv
// Decimal digit counter: repeatedly divides the captured operand by 10, one digit per enabled cycle.
// Optional DIGIT_LEN_BCD_EN adds the bcd output holding the extracted digits (LSD first).
module digit_len_seq #(
  parameter int W    = 34,
  parameter int MAXD = 10,
  parameter int LW   = $clog2(MAXD+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic [W-1:0]    in,
  input  logic            pad_even,
  output logic            busy,
  output logic            done,
  output logic [LW-1:0]   len,
  output logic [LW:0]     len_even,
`ifdef DIGIT_LEN_BCD_EN
  output logic [4*MAXD-1:0] bcd,
`endif
  output logic            ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, nxt;
  logic [W-1:0]  temp;
  logic [W-1:0]  quot;
  logic [3:0]    digit;
  logic [LW-1:0] cnt;
  logic          mode;
  logic          finish;

  assign quot   = temp / W'(10);
  assign digit  = 4'(temp % W'(10));
  // Stop on exhausted operand or once the digit budget is spent (overflow case).
  assign finish = (temp == '0) || (cnt == LW'(MAXD));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= IDLE;
    else if (en) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (finish) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp     <= '0;
      cnt      <= '0;
      mode     <= 1'b0;
      done     <= 1'b0;
      len      <= '0;
      len_even <= '0;
      ovf      <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (start) begin
          temp <= in;
          mode <= pad_even;
          cnt  <= '0;
        end
        RUN: begin
          if (!finish) begin
            temp <= quot;
            cnt  <= cnt + 1'b1;
          end else begin
            len      <= cnt;
            ovf      <= (temp != '0);
            len_even <= (LW+1)'(cnt) + (LW+1)'(mode & cnt[0]);
            done     <= 1'b1;
          end
        end
        DONE:    done <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef DIGIT_LEN_BCD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= '0;
    end else if (en) begin
      if (state == IDLE && start) begin
        bcd <= '0;
      end else if (state == RUN && !finish) begin
        for (int i = 0; i < MAXD; i++)
          if (cnt == LW'(i)) bcd[i*4 +: 4] <= digit;
      end
    end
  end
`endif

endmodule
